// File: rtl/gpio_arbiter.sv
// gpio_arbiter: round-robin exclusive owner of the shared GPIO pins, with an oe-low turnaround between owners.
// Define GPIO_ARB_TIMEOUT_EN to force a release after MAX_HOLD cycles while another requester waits.
module gpio_arbiter #(
    parameter int NR_GPIOS    = 3,
    parameter int NR_REQ      = 2,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NR_REQ-1:0]          req,
    input  logic [NR_REQ*NR_GPIOS-1:0] req_out,
    input  logic [NR_REQ*NR_GPIOS-1:0] req_oe,
    output logic [NR_REQ-1:0]          gnt,
    output logic                       busy,
    output logic [NR_GPIOS-1:0]        gpio_out,
    output logic [NR_GPIOS-1:0]        gpio_oe
);
    // state      | meaning
    // IDLE       | no owner, oe low, arbitrate on any req
    // GRANT      | owner drives the pins through one register stage
    // TURNAROUND | oe forced low for TURN_CYCLES before the next arbitration

    localparam int OW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [OW-1:0] LAST_REQ  = OW'(NR_REQ - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

    if (NR_REQ < 2 || NR_REQ > 8 || TURN_CYCLES < 1 || MAX_HOLD < 2) begin : g_param_check
        $error("gpio_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        TURNAROUND = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NR_REQ-1:0]   gnt_q, gnt_d;
    logic                busy_q, busy_d;
    logic [NR_GPIOS-1:0] out_q, out_d;
    logic [NR_GPIOS-1:0] oe_q, oe_d;
    logic [OW-1:0]       last_q, last_d;
    logic [TW-1:0]       turn_q, turn_d;
    logic [OW-1:0]       win;
    logic                win_valid;
    logic                owner_req;
    logic                release_now;

    // Later overwrites win, so the requester closest after last_q has highest priority.
    always_comb begin
        win       = last_q;
        win_valid = 1'b0;
        for (int k = NR_REQ; k >= 1; k--) begin
            if (req[(int'(last_q) + k) % NR_REQ]) begin
                win       = OW'((int'(last_q) + k) % NR_REQ);
                win_valid = 1'b1;
            end
        end
    end

    assign owner_req = req[last_q];

`ifdef GPIO_ARB_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          others_waiting;

    assign others_waiting = |(req & ~gnt_q);
    assign release_now    = !owner_req || (hold_q == HOLD_LAST && others_waiting);

    always_comb begin
        hold_d = hold_q;
        if (state_d == GRANT && state_q != GRANT) begin
            hold_d = '0;
        end else if (state_q == GRANT && hold_q != HOLD_LAST) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) hold_q <= '0;
        else       hold_q <= hold_d;
    end
`else
    assign release_now = !owner_req;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        out_d   = out_q;
        oe_d    = oe_q;
        last_d  = last_q;
        turn_d  = turn_q;
        case (state_q)
            IDLE: begin
                oe_d = '0;
                if (win_valid) begin
                    state_d = GRANT;
                    gnt_d   = NR_REQ'(1) << win;
                    last_d  = win;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = TURNAROUND;
                    gnt_d   = '0;
                    oe_d    = '0;
                    turn_d  = '0;
                end else begin
                    out_d = req_out[int'(last_q)*NR_GPIOS +: NR_GPIOS];
                    oe_d  = req_oe[int'(last_q)*NR_GPIOS +: NR_GPIOS];
                end
            end
            TURNAROUND: begin
                oe_d  = '0;
                gnt_d = '0;
                if (turn_q == TURN_LAST) begin
                    if (win_valid) begin
                        state_d = GRANT;
                        gnt_d   = NR_REQ'(1) << win;
                        last_d  = win;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                oe_d    = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            out_q   <= '0;
            oe_q    <= '0;
            last_q  <= LAST_REQ;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
            last_q  <= last_d;
            turn_q  <= turn_d;
        end
    end

    assign gnt      = gnt_q;
    assign busy     = busy_q;
    assign gpio_out = out_q;
    assign gpio_oe  = oe_q;

endmodule

// File: tb/tb_gpio_arbiter.sv
// tb_gpio_arbiter: directed vectors push expected post-edge outputs into a queue; a negedge monitor pops and compares.
// Instance uses TURN_CYCLES=3 and MAX_HOLD=8; timeout expectations follow GPIO_ARB_TIMEOUT_EN.
module tb_gpio_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [5:0] req_out;
    logic [5:0] req_oe;
    logic [1:0] gnt;
    logic       busy;
    logic [2:0] gpio_out;
    logic [2:0] gpio_oe;

    logic [8:0] exp_q[$];
    string      name_q[$];
    logic [8:0] exp_v;
    string      exp_nm;
    int         n_pass  = 0;
    int         n_total = 0;
    logic [2:0] p_o0, p_e0, p_o1, p_e1;

    gpio_arbiter #(
        .NR_GPIOS   (3),
        .NR_REQ     (2),
        .TURN_CYCLES(3),
        .MAX_HOLD   (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_out (req_out),
        .req_oe  (req_oe),
        .gnt     (gnt),
        .busy    (busy),
        .gpio_out(gpio_out),
        .gpio_oe (gpio_oe)
    );

    always #5 clk = ~clk;

    task automatic set_pins(input logic [2:0] o0, input logic [2:0] e0,
                            input logic [2:0] o1, input logic [2:0] e1);
        p_o0 = o0;
        p_e0 = e0;
        p_o1 = o1;
        p_e1 = e1;
    endtask

    // Drives one cycle of inputs and queues the outputs expected after the following posedge.
    task automatic step(input logic rst, input logic [1:0] r,
                        input logic [1:0] eg, input logic eb,
                        input logic [2:0] eo, input logic [2:0] eoe, input string nm);
        @(negedge clk);
        #1;
        reset   = rst;
        req     = r;
        req_out = {p_o1, p_o0};
        req_oe  = {p_e1, p_e0};
        exp_q.push_back({eg, eb, eo, eoe});
        name_q.push_back(nm);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp_v  = exp_q.pop_front();
                exp_nm = name_q.pop_front();
                n_total++;
                if ({gnt, busy, gpio_out, gpio_oe} === exp_v) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got gnt=%b busy=%b out=%b oe=%b, expected gnt=%b busy=%b out=%b oe=%b",
                             exp_nm, gnt, busy, gpio_out, gpio_oe,
                             exp_v[8:7], exp_v[6], exp_v[5:3], exp_v[2:0]);
                end
                n_total++;
                if (gnt === 2'b00 && gpio_oe !== 3'b000) begin
                    $display("FAIL oe_without_gnt (%s): got oe=%b with gnt=00, expected oe=000", exp_nm, gpio_oe);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        req     = 2'b00;
        req_out = '0;
        req_oe  = '0;

        set_pins(3'b110, 3'b011, 3'b000, 3'b000);
        step(1, 2'b00, 2'b00, 0, 3'b000, 3'b000, "reset");
        step(0, 2'b00, 2'b00, 0, 3'b000, 3'b000, "idle");
        step(0, 2'b01, 2'b01, 1, 3'b000, 3'b000, "grant0");
        step(0, 2'b01, 2'b01, 1, 3'b110, 3'b011, "pass0");
        step(1, 2'b01, 2'b00, 0, 3'b000, 3'b000, "reset_mid_grant");
        step(0, 2'b00, 2'b00, 0, 3'b000, 3'b000, "idle_after_reset");

        set_pins(3'b001, 3'b111, 3'b101, 3'b111);
        step(0, 2'b11, 2'b01, 1, 3'b000, 3'b000, "rr_first");
        step(0, 2'b11, 2'b01, 1, 3'b001, 3'b111, "pass0b");
        step(0, 2'b10, 2'b00, 1, 3'b001, 3'b000, "release0");
        repeat (2) step(0, 2'b10, 2'b00, 1, 3'b001, 3'b000, "turn_a");
        step(0, 2'b10, 2'b10, 1, 3'b001, 3'b000, "grant1");
        step(0, 2'b10, 2'b10, 1, 3'b101, 3'b111, "pass1");
        set_pins(3'b010, 3'b000, 3'b101, 3'b111);
        step(0, 2'b10, 2'b10, 1, 3'b101, 3'b111, "nonowner_ignored");
        set_pins(3'b010, 3'b000, 3'b011, 3'b100);
        step(0, 2'b10, 2'b10, 1, 3'b011, 3'b100, "pass1b");
        step(0, 2'b01, 2'b00, 1, 3'b011, 3'b000, "release1");
        repeat (2) step(0, 2'b01, 2'b00, 1, 3'b011, 3'b000, "turn_b");
        step(0, 2'b11, 2'b01, 1, 3'b011, 3'b000, "prev_owner_low_prio");
        set_pins(3'b111, 3'b101, 3'b011, 3'b100);
        step(0, 2'b11, 2'b01, 1, 3'b111, 3'b101, "pass0c");

`ifdef GPIO_ARB_TIMEOUT_EN
        repeat (6) step(0, 2'b11, 2'b01, 1, 3'b111, 3'b101, "hold0");
        step(0, 2'b11, 2'b00, 1, 3'b111, 3'b000, "forced_release");
        repeat (2) step(0, 2'b11, 2'b00, 1, 3'b111, 3'b000, "turn_c");
        step(0, 2'b11, 2'b10, 1, 3'b111, 3'b000, "preempt_grant1");
        step(0, 2'b10, 2'b10, 1, 3'b011, 3'b100, "pass1c");
`else
        repeat (1000) step(0, 2'b11, 2'b01, 1, 3'b111, 3'b101, "hold0_no_timeout");
        step(0, 2'b10, 2'b00, 1, 3'b111, 3'b000, "release0b");
        repeat (2) step(0, 2'b10, 2'b00, 1, 3'b111, 3'b000, "turn_c");
        step(0, 2'b10, 2'b10, 1, 3'b111, 3'b000, "grant1b");
        step(0, 2'b10, 2'b10, 1, 3'b011, 3'b100, "pass1c");
`endif

        step(0, 2'b00, 2'b00, 1, 3'b011, 3'b000, "release1b");
        step(0, 2'b01, 2'b00, 1, 3'b011, 3'b000, "pulse_in_turn");
        step(0, 2'b00, 2'b00, 1, 3'b011, 3'b000, "turn_d");
        step(0, 2'b00, 2'b00, 0, 3'b011, 3'b000, "pulse_lost");
        step(0, 2'b00, 2'b00, 0, 3'b011, 3'b000, "idle_hold_out");

        step(0, 2'b01, 2'b01, 1, 3'b011, 3'b000, "single_grant");
        step(0, 2'b01, 2'b01, 1, 3'b111, 3'b101, "single_pass");
        step(0, 2'b00, 2'b00, 1, 3'b111, 3'b000, "single_release");
        repeat (2) step(0, 2'b01, 2'b00, 1, 3'b111, 3'b000, "single_turn");
        step(0, 2'b01, 2'b01, 1, 3'b111, 3'b000, "single_regrant");
        step(0, 2'b01, 2'b01, 1, 3'b111, 3'b101, "single_pass2");
        step(1, 2'b01, 2'b00, 0, 3'b000, 3'b000, "final_reset");

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expected entries left unchecked, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/gpio_arbiter.md
Name: gpio_arbiter

Overview:
Shares the board GPIO pins (LEDs, button-side pins) between several requesters. Typical requesters are the JTAG GPIO register block, after its outputs are synchronized into clk, and local fabric logic such as the LED blinker. Requesters get exclusive, round-robin ownership with a mandatory output-disable turnaround between owners. The block drives the registered out/oe vectors that feed the top-level tristate assigns.

Parameters:
NR_GPIOS, 3, number of shared GPIO pins.
NR_REQ, 2, number of requesters (2..8).
TURN_CYCLES, 1, turnaround length in clk cycles with all oe forced low (min 1).
MAX_HOLD, 256, max cycles an owner keeps the pins while another requester waits (used only with the optional feature).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  NR_REQ  per-requester ownership request, level
req_out  input  NR_REQ*NR_GPIOS  output values; requester i uses slice [i*NR_GPIOS +: NR_GPIOS]
req_oe  input  NR_REQ*NR_GPIOS  output enables; same slicing as req_out
gnt  output  NR_REQ  one-hot grant, registered
busy  output  1  high while in GRANT or TURNAROUND
gpio_out  output  NR_GPIOS  registered pin output value
gpio_oe  output  NR_GPIOS  registered pin output enable

Behaviour:
- Reset, synchronous and active-high, clears state in one edge, including mid-grant.
  - state=IDLE, gnt=0, busy=0, gpio_out=0, gpio_oe=0, hold counter=0, turn counter=0.
  - last_owner=NR_REQ-1, so requester 0 wins first.
- States: IDLE, GRANT, TURNAROUND.
- IDLE:
  - gpio_oe=0; gpio_out holds its last value.
  - If any req is high at an edge, pick winner w by round-robin: search from last_owner+1 upward, mod NR_REQ.
  - Same edge: gnt[w]=1, last_owner=w, state=GRANT.
  - Latency: req high at edge n gives gnt visible after edge n.
- GRANT:
  - Each edge: gpio_out/gpio_oe <= owner's req_out/req_oe slices. This is one cycle of latency from the requester's inputs to the pins.
  - Non-owner req_out/req_oe are ignored.
  - Owner req low at an edge: gnt=0, gpio_oe=0, turn counter=0, state=TURNAROUND. The owner's values are not sampled on that edge.
  - gnt stays one-hot or zero at all times.
- TURNAROUND:
  - gpio_oe=0; gpio_out holds; gnt=0; busy=1.
  - Lasts exactly TURN_CYCLES cycles.
  - On its final edge: if any req is high, arbitrate as in IDLE and go to GRANT directly (no extra IDLE cycle). Otherwise go to IDLE.
  - The previous owner is eligible again but has the lowest priority.
- Requests arriving or dropping during TURNAROUND only matter when sampled at the final edge.
- A req pulse that falls before it is sampled at an arbitration edge is lost; no queuing.
- Single requester: it regains the pins after every release; the turnaround still applies.
- busy = (state != IDLE), registered with the state.

Optional Feature:
Macro GPIO_ARB_TIMEOUT_EN.
- Defined:
  - The hold counter counts GRANT cycles from 0 and saturates at MAX_HOLD-1.
  - Forced release happens at an edge where the counter equals MAX_HOLD-1 and any non-owner req is high. Effect: gnt=0, oe=0, state=TURNAROUND, exactly as a voluntary release.
  - The preempted owner must keep req high to compete again; it gets the lowest priority.
  - If the owner drops req on the same edge, the release is treated as voluntary; the result is identical.
  - The counter clears on entry to GRANT.
  - With no other requester pending, the owner holds the pins indefinitely.
- Undefined: no counter logic is synthesized; the owner holds the pins until it drops req.

Test Plan:
- Reset mid-grant: req=2'b01, gnt=2'b01, gpio_oe=3'b011; assert reset 1 cycle -> next cycle gnt=0, gpio_oe=0, gpio_out=0, busy=0.
- Simultaneous first request: req=2'b11 from IDLE -> gnt=2'b01 after 1 edge. Req0 drops -> gpio_oe=0 for exactly TURN_CYCLES=1 cycle, then gnt=2'b10.
- Passthrough latency: owner 1 sets req_out slice=3'b101, oe=3'b111 at edge n -> gpio_out=3'b101, gpio_oe=3'b111 after edge n. Non-owner slice changes leave pins unchanged.
- Turnaround length: TURN_CYCLES=3, owner releases with the other req high -> gpio_oe=0 and gnt=0 for exactly 3 cycles, then the new grant. Assert gpio_oe never nonzero while gnt=0.
- Timeout (GPIO_ARB_TIMEOUT_EN, MAX_HOLD=8): req0 granted and held, req1 raised -> forced release 8 cycles after grant, gnt=2'b10 after turnaround. Repeat without the macro: req0 keeps gnt for 1000 cycles.
- Single requester re-request: req=2'b01 toggled low 1 cycle then high -> IDLE/TURNAROUND pass, gnt=2'b01 again, oe low for ≥TURN_CYCLES cycles.
